pointwise_mul_seq: RTL

//  Sequencer for pointwise modular multiplication of two length-N Kyber polynomials (q=3329).

---
 rtl/pointwise_mul_seq.sv | 110 +++++++++++
 1 files changed

// File: rtl/pointwise_mul_seq.sv
// Sequencer for pointwise modular multiplication of two Kyber polynomials (q = 3329).
// Streams coefficient pairs from two sync-read RAMs through an external multiplier into a destination RAM.
module pointwise_mul_seq #(
  parameter int N       = 256,
  parameter int ADDR_W  = 8,
  parameter int RD_LAT  = 1,
  parameter int MUL_LAT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [11:0]       a_rdata,
  input  logic [11:0]       b_rdata,
  output logic [11:0]       mul_a,
  output logic [11:0]       mul_b,
  input  logic [11:0]       mul_result,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [11:0]       wr_data
);

  // Each issued read reaches the write port after the RAM read plus the multiplier latency.
  localparam int PIPE_D = RD_LAT + MUL_LAT;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [PIPE_D-1:0] pipe_vld_q;
  logic [ADDR_W-1:0] pipe_addr_q [PIPE_D];

  logic last_issue;
  logic pipe_busy;
  logic flush;

  assign last_issue = (rd_addr_q == ADDR_W'(N - 1));
  // The tail stage is writing this cycle; the job is finished once nothing sits behind it.
  assign pipe_busy  = |pipe_vld_q[PIPE_D-2:0];
  assign flush      = abort && busy;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start && !abort) state_d = S_RUN;
      S_RUN: begin
        if (abort)           state_d = S_IDLE;
        else if (last_issue) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort)           state_d = S_IDLE;
        else if (!pipe_busy) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      rd_addr_q <= '0;
    end else begin
      state_q <= state_d;
      // Counter sits at zero outside RUN, so each job starts from coefficient 0 without extra control.
      if (state_q == S_RUN && !abort && !last_issue) rd_addr_q <= rd_addr_q + 1'b1;
      else                                           rd_addr_q <= '0;
    end
  end

  // NOTE: the address pipe is reset along with the valids because its tail drives wr_addr, which must read 0 in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_vld_q <= '0;
      for (int i = 0; i < PIPE_D; i++) pipe_addr_q[i] <= '0;
    end else begin
      // Abort drops everything in flight, including the read issued this cycle.
      if (flush) pipe_vld_q <= '0;
      else       pipe_vld_q <= {pipe_vld_q[PIPE_D-2:0], rd_en};
      pipe_addr_q[0] <= rd_addr_q;
      for (int i = 1; i < PIPE_D; i++) pipe_addr_q[i] <= pipe_addr_q[i-1];
    end
  end

  assign rd_en   = (state_q == S_RUN);
  assign rd_addr = rd_addr_q;
  assign busy    = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done    = (state_q == S_DONE);

  // Operands flow every cycle; results are only consumed when the tag pipe marks them valid.
  assign mul_a   = a_rdata;
  assign mul_b   = b_rdata;

  assign wr_en   = pipe_vld_q[PIPE_D-1];
  assign wr_addr = pipe_addr_q[PIPE_D-1];
  assign wr_data = wr_en ? mul_result : '0;

endmodule
